rr_mux3_arbiter: RTL and testbench

// - Round-robin arbiter and registered output stage for three K-bit valid/ready sources.
// - Sits directly upstream of a 3-way word mux. It generates the one-hot select for the

---
 rtl/rr_mux3_arbiter_pkg.sv | 28 ++
 rtl/mux3.sv | 21 ++
 rtl/rr_mux3_arbiter_pick3.sv | 38 +++
 rtl/rr_mux3_arbiter.sv | 76 +++++++
 tb/tb_rr_mux3_arbiter.sv | 185 ++++++++++++++++++
 5 files changed

// File: rtl/rr_mux3_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// rr_mux3_arbiter_pkg : shared select codes and pointer type for rr_mux3_arbiter
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package rr_mux3_arbiter_pkg;

  localparam logic [2:0] SEL_NONE = 3'b000;
  localparam logic [2:0] SEL_A0   = 3'b001;
  localparam logic [2:0] SEL_A1   = 3'b010;
  localparam logic [2:0] SEL_A2   = 3'b100;

  typedef enum logic [1:0] {
    P0 = 2'd0,
    P1 = 2'd1,
    P2 = 2'd2
  } ptr_t;

  function automatic ptr_t grant_to_ptr(input logic [2:0] g);
    if (g[0])      return P0;
    else if (g[1]) return P1;
    else           return P2;
  endfunction

endpackage

`default_nettype wire

// File: rtl/mux3.sv
// ---------------------------------------------------------------------------
// Mux3 : K-bit three-way word mux driven by a one-hot select (zero when s=000)
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module Mux3 #(
  parameter int K = 4
) (
  input  logic [K-1:0] a2,
  input  logic [K-1:0] a1,
  input  logic [K-1:0] a0,
  input  logic [2:0]   s,
  output logic [K-1:0] b
);

  assign b = ({K{s[0]}} & a0) | ({K{s[1]}} & a1) | ({K{s[2]}} & a2);

endmodule

`default_nettype wire

// File: rtl/rr_mux3_arbiter_pick3.sv
// ---------------------------------------------------------------------------
// rr_pick3 : combinational round-robin pick, search starts after last_grant
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module rr_pick3
  import rr_mux3_arbiter_pkg::*;
(
  input  logic [2:0] valid,
  input  ptr_t       last_grant,
  output logic [2:0] grant
);

  always_comb begin
    grant = SEL_NONE;
    case (last_grant)
      P0: begin
        if (valid[1])      grant = SEL_A1;
        else if (valid[2]) grant = SEL_A2;
        else if (valid[0]) grant = SEL_A0;
      end
      P1: begin
        if (valid[2])      grant = SEL_A2;
        else if (valid[0]) grant = SEL_A0;
        else if (valid[1]) grant = SEL_A1;
      end
      default: begin
        if (valid[0])      grant = SEL_A0;
        else if (valid[1]) grant = SEL_A1;
        else if (valid[2]) grant = SEL_A2;
      end
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/rr_mux3_arbiter.sv
// ---------------------------------------------------------------------------
// rr_mux3_arbiter : round-robin arbiter with one-entry registered output stage
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module rr_mux3_arbiter
  import rr_mux3_arbiter_pkg::*;
#(
  parameter int K = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         a0_valid,
  input  logic [K-1:0] a0_data,
  output logic         a0_ready,
  input  logic         a1_valid,
  input  logic [K-1:0] a1_data,
  output logic         a1_ready,
  input  logic         a2_valid,
  input  logic [K-1:0] a2_data,
  output logic         a2_ready,
  output logic         out_valid,
  output logic [K-1:0] out_data,
  input  logic         out_ready,
  output logic [2:0]   sel
);

  ptr_t         last_grant;
  logic [2:0]   grant;
  logic [K-1:0] mux_word;
  logic         load_en;
  logic         transfer;

  rr_pick3 u_pick (
    .valid      ({a2_valid, a1_valid, a0_valid}),
    .last_grant (last_grant),
    .grant      (grant)
  );

  Mux3 #(.K(K)) u_mux (
    .a2 (a2_data),
    .a1 (a1_data),
    .a0 (a0_data),
    .s  (grant),
    .b  (mux_word)
  );

  assign load_en  = !out_valid || out_ready;
  assign transfer = load_en && (grant != SEL_NONE);

  // Readys are masked by reset so they drop the moment reset asserts.
  assign a0_ready = load_en && grant[0] && !reset;
  assign a1_ready = load_en && grant[1] && !reset;
  assign a2_ready = load_en && grant[2] && !reset;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid  <= 1'b0;
      out_data   <= '0;
      sel        <= SEL_NONE;
      last_grant <= P2;
    end else if (transfer) begin
      out_valid  <= 1'b1;
      out_data   <= mux_word;
      sel        <= grant;
      last_grant <= grant_to_ptr(grant);
    end else if (out_valid && out_ready) begin
      out_valid  <= 1'b0;
      sel        <= SEL_NONE;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_rr_mux3_arbiter.sv
// ---------------------------------------------------------------------------
// tb_rr_mux3_arbiter : directed self-checking bench for rr_mux3_arbiter
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_rr_mux3_arbiter;

  logic       clk = 1'b0;
  logic       reset = 1'b1;

  // K=4 instance
  logic       a0_valid = 0, a1_valid = 0, a2_valid = 0;
  logic [3:0] a0_data = 0, a1_data = 0, a2_data = 0;
  logic       a0_ready, a1_ready, a2_ready;
  logic       out_valid;
  logic [3:0] out_data;
  logic       out_ready = 0;
  logic [2:0] sel;

  // K=8 instance
  logic       c0_valid = 0, c1_valid = 0, c2_valid = 0;
  logic [7:0] c0_data = 0, c1_data = 0, c2_data = 0;
  logic       c0_ready, c1_ready, c2_ready;
  logic       c_out_valid;
  logic [7:0] c_out_data;
  logic       c_out_ready = 0;
  logic [2:0] c_sel;

  int tests = 0;
  int failures = 0;

  always #5 clk = ~clk;

  rr_mux3_arbiter #(.K(4)) dut (
    .clk(clk), .reset(reset),
    .a0_valid(a0_valid), .a0_data(a0_data), .a0_ready(a0_ready),
    .a1_valid(a1_valid), .a1_data(a1_data), .a1_ready(a1_ready),
    .a2_valid(a2_valid), .a2_data(a2_data), .a2_ready(a2_ready),
    .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
    .sel(sel)
  );

  rr_mux3_arbiter #(.K(8)) dut8 (
    .clk(clk), .reset(reset),
    .a0_valid(c0_valid), .a0_data(c0_data), .a0_ready(c0_ready),
    .a1_valid(c1_valid), .a1_data(c1_data), .a1_ready(c1_ready),
    .a2_valid(c2_valid), .a2_data(c2_data), .a2_ready(c2_ready),
    .out_valid(c_out_valid), .out_data(c_out_data), .out_ready(c_out_ready),
    .sel(c_sel)
  );

  wire [2:0] rdy  = {a2_ready, a1_ready, a0_ready};
  wire [2:0] rdy8 = {c2_ready, c1_ready, c0_ready};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  logic [2:0] t1_sel  [4] = '{3'b001, 3'b010, 3'b100, 3'b001};
  logic [3:0] t1_data [4] = '{4'd1, 4'd2, 4'd4, 4'd1};

  initial begin
    // Test 1: reset state, then a0,a1,a2,a0 rotation
    a0_valid = 1; a1_valid = 1; a2_valid = 1;
    a0_data = 4'd1; a1_data = 4'd2; a2_data = 4'd4;
    out_ready = 1;
    #12;
    check("rst_valid", {31'd0, out_valid}, 32'd0);
    check("rst_data",  {28'd0, out_data}, 32'd0);
    check("rst_sel",   {29'd0, sel}, 32'd0);
    check("rst_ready", {29'd0, rdy}, 32'd0);
    @(negedge clk);
    reset = 0;
    #1;
    for (int i = 0; i < 4; i++) begin
      check("t1_ready", {29'd0, rdy}, {29'd0, t1_sel[i]});
      tick();
      check("t1_valid", {31'd0, out_valid}, 32'd1);
      check("t1_sel",   {29'd0, sel}, {29'd0, t1_sel[i]});
      check("t1_data",  {28'd0, out_data}, {28'd0, t1_data[i]});
    end

    // Test 2: only a1 valid
    a0_valid = 0; a2_valid = 0; a1_data = 4'd7;
    #1;
    for (int i = 0; i < 3; i++) begin
      check("t2_ready", {29'd0, rdy}, 32'd2);
      tick();
      check("t2_valid", {31'd0, out_valid}, 32'd1);
      check("t2_data",  {28'd0, out_data}, 32'd7);
      check("t2_sel",   {29'd0, sel}, 32'd2);
    end

    // Test 3: load a0=3, stall four cycles, then a1 wins
    a1_valid = 0; a0_valid = 1; a0_data = 4'd3;
    #1;
    check("t3_ld_ready", {29'd0, rdy}, 32'd1);
    tick();
    check("t3_ld_data", {28'd0, out_data}, 32'd3);
    out_ready = 0;
    a1_valid = 1; a1_data = 4'd2; a2_valid = 1; a2_data = 4'd4;
    for (int i = 0; i < 4; i++) begin
      #1;
      check("t3_stall_ready", {29'd0, rdy}, 32'd0);
      tick();
      check("t3_stall_valid", {31'd0, out_valid}, 32'd1);
      check("t3_stall_data",  {28'd0, out_data}, 32'd3);
      check("t3_stall_sel",   {29'd0, sel}, 32'd1);
    end
    out_ready = 1;
    #1;
    check("t3_next_ready", {29'd0, rdy}, 32'd2);
    tick();
    check("t3_next_data", {28'd0, out_data}, 32'd2);
    check("t3_next_sel",  {29'd0, sel}, 32'd2);

    // Test 4: single word from a2 then drain
    a0_valid = 0; a1_valid = 0; a2_data = 4'd5;
    tick();
    check("t4_valid", {31'd0, out_valid}, 32'd1);
    check("t4_data",  {28'd0, out_data}, 32'd5);
    check("t4_sel",   {29'd0, sel}, 32'd4);
    a2_valid = 0;
    tick();
    check("t4_drain_valid", {31'd0, out_valid}, 32'd0);
    check("t4_drain_sel",   {29'd0, sel}, 32'd0);
    check("t4_drain_data",  {28'd0, out_data}, 32'd5);
    tick();
    check("t4_idle_valid", {31'd0, out_valid}, 32'd0);

    // Test 5: async reset while holding 6
    a0_valid = 1; a0_data = 4'd6;
    tick();
    check("t5_pre_data", {28'd0, out_data}, 32'd6);
    #2;
    reset = 1;
    #1;
    check("t5_rst_valid", {31'd0, out_valid}, 32'd0);
    check("t5_rst_data",  {28'd0, out_data}, 32'd0);
    check("t5_rst_sel",   {29'd0, sel}, 32'd0);
    check("t5_rst_ready", {29'd0, rdy}, 32'd0);
    @(negedge clk);
    reset = 0;
    a1_valid = 1; a2_valid = 1;
    #1;
    check("t5_first_ready", {29'd0, rdy}, 32'd1);
    tick();
    check("t5_first_sel",  {29'd0, sel}, 32'd1);
    check("t5_first_data", {28'd0, out_data}, 32'd6);

    // Test 6: K=8, pointer at P0, a2 served before a0
    c_out_ready = 1; c0_valid = 1; c0_data = 8'h11;
    #1;
    check("t6_prime_ready", {29'd0, rdy8}, 32'd1);
    tick();
    check("t6_prime_data", {24'd0, c_out_data}, 32'h11);
    c0_data = 8'hA5; c2_valid = 1; c2_data = 8'h3C;
    #1;
    check("t6_first_ready", {29'd0, rdy8}, 32'd4);
    tick();
    check("t6_first_data", {24'd0, c_out_data}, 32'h3C);
    check("t6_first_sel",  {29'd0, c_sel}, 32'd4);
    #1;
    check("t6_second_ready", {29'd0, rdy8}, 32'd1);
    tick();
    check("t6_second_data", {24'd0, c_out_data}, 32'hA5);
    check("t6_second_sel",  {29'd0, c_sel}, 32'd1);

    $display("[TB] %0d tests run, %0d failed", tests, failures);
    $finish;
  end

endmodule

`default_nettype wire
